au_abs_accum: RTL

Streaming magnitude accumulator that sits directly downstream of the combinational absolute-value stage. It accepts signed two's-complement samples over a valid/ready handshake and forms each sample's magnitude with the same semantics as that stage. It sums the magnitudes over blocks of LEN samples, or fewer when a block is flushed early, and presents each block total on a second valid/ready handshake. Typical use: sum-of-absolute-values and L1-norm or SAD-style metrics.

---
 rtl/au_abs_accum.sv | 81 ++++++++
 1 files changed

// File: rtl/au_abs_accum.sv
// Streaming sum-of-magnitudes accumulator: takes signed samples, sums |a| over
// blocks of LEN (or fewer on flush) and offers each block total on a handshake.
module au_abs_accum #(
  parameter int WIDTH = 8,
  parameter int LEN = 16,
  localparam int ACC_WIDTH = WIDTH + $clog2(LEN),
  localparam int CNT_WIDTH = $clog2(LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic [CNT_WIDTH-1:0] cnt
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [CNT_WIDTH-1:0] n, n_next;
  logic [WIDTH-1:0]     mag;
  logic                 close;

  // The most-negative input negates to itself, which read unsigned is 2^(WIDTH-1).
  assign mag = a[WIDTH-1] ? (~a + 1'b1) : a;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    n_next     = n;
    close      = 1'b0;
    in_ready   = (state == ACC);
    out_valid  = (state == HOLD);
    case (state)
      ACC: begin
        if (in_valid) begin
          acc_next = acc + ACC_WIDTH'(mag);
          n_next   = n + 1'b1;
        end
        // A flush closes only a non-empty block, counting a same-cycle sample.
        close = (in_valid && n_next == CNT_WIDTH'(LEN)) || (flush && n_next != '0);
        if (close) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      n     <= '0;
      sum   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (close) begin
        sum <= acc_next;
        cnt <= n_next;
        acc <= '0;
        n   <= '0;
      end else begin
        acc <= acc_next;
        n   <= n_next;
      end
    end
  end

endmodule
